// File: rtl/reg_file_seq_pkg.sv
// Shared definitions for the register-file command sequencer.
//   op_t    : command opcodes carried on cmd_op
//   state_t : sequencer state encoding
package reg_file_seq_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_COPY  = 2'b10,   // x <= y
        OP_SWAP  = 2'b11    // x <-> y
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WR1   = 3'd2,
        ST_WR2   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_file.sv
// 16-entry register file: two combinational read ports (A, B) and one
// synchronous write port sharing the A address. All registers reset to
// RESET_VAL. Addresses with non-zero upper bits read as zero and are never
// written.
//   clk, a_reset_l          : clock, asynchronous active-low reset
//   a_adr_in, b_adr_in      : read addresses (A also selects the write target)
//   reg_a_in, we            : write data and write enable
//   reg_a_out, reg_b_out    : read data
module reg_file #(
    parameter int                    DATA_WL   = 16,
    parameter int                    ADR_WL    = 7,
    parameter logic [DATA_WL-1:0]    RESET_VAL = 16'd10
) (
    input  logic               clk,
    input  logic               a_reset_l,
    input  logic [ADR_WL-1:0]  a_adr_in,
    input  logic [ADR_WL-1:0]  b_adr_in,
    input  logic [DATA_WL-1:0] reg_a_in,
    input  logic               we,
    output logic [DATA_WL-1:0] reg_a_out,
    output logic [DATA_WL-1:0] reg_b_out
);
    logic [DATA_WL-1:0] mem_q [16];

    logic a_in_range, b_in_range;
    assign a_in_range = (a_adr_in[ADR_WL-1:4] == '0);
    assign b_in_range = (b_adr_in[ADR_WL-1:4] == '0);

    assign reg_a_out = a_in_range ? mem_q[a_adr_in[3:0]] : '0;
    assign reg_b_out = b_in_range ? mem_q[b_adr_in[3:0]] : '0;

    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            for (int i = 0; i < 16; i++) mem_q[i] <= RESET_VAL;
        end else if (we && a_in_range) begin
            mem_q[a_adr_in[3:0]] <= reg_a_in;
        end
    end

endmodule

// File: rtl/reg_file_seq.sv
// Command-driven initiator for the register file. Accepts READ / WRITE /
// COPY / SWAP commands on a valid/ready handshake, sequences them into
// register-file port cycles and returns the pre-operation values of both
// addressed registers as a single response.
//   clk, a_reset_l                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_op, cmd_x, cmd_y, cmd_wdata: command fields
//   rsp_valid/rsp_ready            : response handshake
//   rsp_a, rsp_b                   : pre-op values of reg x and reg y
//   busy                           : high whenever not idle
//   rf_a_adr, rf_b_adr, rf_wdata,
//   rf_we                          : register-file master port (all registered)
//   rf_a_dout, rf_b_dout           : register-file read data
module reg_file_seq
    import reg_file_seq_pkg::*;
#(
    parameter int DATA_WL    = 16,
    parameter int REG_ADR_WL = 4,
    parameter int RF_ADR_WL  = 7
) (
    input  logic                  clk,
    input  logic                  a_reset_l,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [REG_ADR_WL-1:0] cmd_x,
    input  logic [REG_ADR_WL-1:0] cmd_y,
    input  logic [DATA_WL-1:0]    cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WL-1:0]    rsp_a,
    output logic [DATA_WL-1:0]    rsp_b,
    output logic                  busy,
    output logic [RF_ADR_WL-1:0]  rf_a_adr,
    output logic [RF_ADR_WL-1:0]  rf_b_adr,
    output logic [DATA_WL-1:0]    rf_wdata,
    output logic                  rf_we,
    input  logic [DATA_WL-1:0]    rf_a_dout,
    input  logic [DATA_WL-1:0]    rf_b_dout
);
    state_t                  state_q;
    op_t                     op_q;
    logic [REG_ADR_WL-1:0]   x_q, y_q;
    logic [DATA_WL-1:0]      wdata_q;
    logic [DATA_WL-1:0]      old_a_q, old_b_q;
    logic                    rsp_valid_q;
    logic [RF_ADR_WL-1:0]    rf_a_adr_q, rf_b_adr_q;
    logic [DATA_WL-1:0]      rf_wdata_q;
    logic                    rf_we_q;

    function automatic logic [RF_ADR_WL-1:0] zext(input logic [REG_ADR_WL-1:0] idx);
        zext = {{(RF_ADR_WL-REG_ADR_WL){1'b0}}, idx};
    endfunction

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_a     = old_a_q;
    assign rsp_b     = old_b_q;
    assign rf_a_adr  = rf_a_adr_q;
    assign rf_b_adr  = rf_b_adr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_we     = rf_we_q;

    // The rf_* registers are loaded with the values belonging to the state
    // being entered, so they are glitch-free and never see cmd_* directly.
    always_ff @(posedge clk or negedge a_reset_l) begin
        if (!a_reset_l) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            x_q         <= '0;
            y_q         <= '0;
            wdata_q     <= '0;
            old_a_q     <= '0;
            old_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rf_a_adr_q  <= '0;
            rf_b_adr_q  <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= op_t'(cmd_op);
                        x_q        <= cmd_x;
                        y_q        <= cmd_y;
                        wdata_q    <= cmd_wdata;
                        rf_a_adr_q <= zext(cmd_x);
                        rf_b_adr_q <= zext(cmd_y);
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    old_a_q <= rf_a_dout;
                    old_b_q <= rf_b_dout;
                    if (op_q == OP_READ) begin
                        rf_a_adr_q  <= '0;
                        rf_b_adr_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        rf_a_adr_q <= zext(x_q);
                        rf_we_q    <= 1'b1;
                        // rf_b_dout is the value being captured into old_b.
                        rf_wdata_q <= (op_q == OP_WRITE) ? wdata_q : rf_b_dout;
                        state_q    <= ST_WR1;
                    end
                end
                ST_WR1: begin
                    if (op_q == OP_SWAP) begin
                        rf_a_adr_q <= zext(y_q);
                        rf_wdata_q <= old_a_q;
                        rf_we_q    <= 1'b1;
                        state_q    <= ST_WR2;
                    end else begin
                        rf_a_adr_q  <= '0;
                        rf_b_adr_q  <= '0;
                        rf_wdata_q  <= '0;
                        rf_we_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WR2: begin
                    rf_a_adr_q  <= '0;
                    rf_b_adr_q  <= '0;
                    rf_wdata_q  <= '0;
                    rf_we_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rf_we_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench: reg_file_seq driving reg_file (registers reset to 10).
module tb_reg_file_seq;
    localparam int DATA_WL    = 16;
    localparam int REG_ADR_WL = 4;
    localparam int RF_ADR_WL  = 7;

    localparam logic [1:0] C_READ  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_COPY  = 2'b10;
    localparam logic [1:0] C_SWAP  = 2'b11;

    logic                  clk = 1'b0;
    logic                  a_reset_l;
    logic                  cmd_valid, cmd_ready;
    logic [1:0]            cmd_op;
    logic [REG_ADR_WL-1:0] cmd_x, cmd_y;
    logic [DATA_WL-1:0]    cmd_wdata;
    logic                  rsp_valid, rsp_ready;
    logic [DATA_WL-1:0]    rsp_a, rsp_b;
    logic                  busy;
    logic [RF_ADR_WL-1:0]  rf_a_adr, rf_b_adr;
    logic [DATA_WL-1:0]    rf_wdata, rf_a_dout, rf_b_dout;
    logic                  rf_we;

    int n_checks = 0;
    int n_fail   = 0;

    // Write pulses observed during the last command.
    int                   we_n;
    logic [RF_ADR_WL-1:0] we_adr [4];
    logic [DATA_WL-1:0]   we_dat [4];
    int                   we_cyc [4];

    always #5 clk = ~clk;

    reg_file_seq #(.DATA_WL(DATA_WL), .REG_ADR_WL(REG_ADR_WL), .RF_ADR_WL(RF_ADR_WL)) dut (
        .clk(clk), .a_reset_l(a_reset_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .busy(busy),
        .rf_a_adr(rf_a_adr), .rf_b_adr(rf_b_adr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rf_a_dout(rf_a_dout), .rf_b_dout(rf_b_dout)
    );

    reg_file #(.DATA_WL(DATA_WL), .ADR_WL(RF_ADR_WL), .RESET_VAL(16'd10)) u_rf (
        .clk(clk), .a_reset_l(a_reset_l),
        .a_adr_in(rf_a_adr), .b_adr_in(rf_b_adr), .reg_a_in(rf_wdata), .we(rf_we),
        .reg_a_out(rf_a_dout), .reg_b_out(rf_b_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, record write pulses, and collect the response.
    // lat counts the accept edge as 1 and ends on the first rsp_valid cycle.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                          input logic [15:0] wd, output int lat,
                          output logic [15:0] ra, output logic [15:0] rb);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_wdata = wd; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_x = 4'hF; cmd_y = 4'hF; cmd_wdata = 16'hDEAD;
        lat = 1; we_n = 0;
        while (!rsp_valid && lat < 20) begin
            if (rf_we && we_n < 4) begin
                we_adr[we_n] = rf_a_adr; we_dat[we_n] = rf_wdata; we_cyc[we_n] = lat;
                we_n++;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) check("rsp_timeout", 32'(lat), 32'd0);
        ra = rsp_a; rb = rsp_b;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] ra, rb;

        a_reset_l = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_x = '0; cmd_y = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 a_reset_l = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rf_we",     32'(rf_we),     32'd0);
        check("rst_rf_a_adr",  32'(rf_a_adr),  32'd0);
        check("rst_rsp_a",     32'(rsp_a),     32'd0);
        @(posedge clk); #1;

        // READ 3,5 on freshly reset file
        do_cmd(C_READ, 4'd3, 4'd5, 16'h0, lat, ra, rb);
        check("read_lat", 32'(lat), 32'd2);
        check("read_a",   32'(ra),  32'd10);
        check("read_b",   32'(rb),  32'd10);
        check("read_we_n", 32'(we_n), 32'd0);

        // WRITE 3 = 0x1234, then READ 3,3
        do_cmd(C_WRITE, 4'd3, 4'd0, 16'h1234, lat, ra, rb);
        check("wr_lat",    32'(lat), 32'd3);
        check("wr_a",      32'(ra),  32'd10);
        check("wr_b",      32'(rb),  32'd10);
        check("wr_we_n",   32'(we_n), 32'd1);
        check("wr_we_adr", 32'(we_adr[0]), 32'd3);
        check("wr_we_dat", 32'(we_dat[0]), 32'h1234);
        do_cmd(C_READ, 4'd3, 4'd3, 16'h0, lat, ra, rb);
        check("rd3_a", 32'(ra), 32'h1234);
        check("rd3_b", 32'(rb), 32'h1234);

        // WRITE 7 = 0xBEEF, COPY 2 <= 7, READ 2,7
        do_cmd(C_WRITE, 4'd7, 4'd0, 16'hBEEF, lat, ra, rb);
        do_cmd(C_COPY, 4'd2, 4'd7, 16'h5555, lat, ra, rb);
        check("copy_lat", 32'(lat), 32'd3);
        check("copy_a",   32'(ra),  32'd10);
        check("copy_b",   32'(rb),  32'hBEEF);
        check("copy_we_n", 32'(we_n), 32'd1);
        check("copy_we_adr", 32'(we_adr[0]), 32'd2);
        do_cmd(C_READ, 4'd2, 4'd7, 16'h0, lat, ra, rb);
        check("rd27_a", 32'(ra), 32'hBEEF);
        check("rd27_b", 32'(rb), 32'hBEEF);

        // Preload 4=1, 9=2, SWAP 4,9, READ 4,9
        do_cmd(C_WRITE, 4'd4, 4'd0, 16'h0001, lat, ra, rb);
        do_cmd(C_WRITE, 4'd9, 4'd0, 16'h0002, lat, ra, rb);
        do_cmd(C_SWAP, 4'd4, 4'd9, 16'h7777, lat, ra, rb);
        check("swap_lat",  32'(lat), 32'd4);
        check("swap_a",    32'(ra),  32'd1);
        check("swap_b",    32'(rb),  32'd2);
        check("swap_we_n", 32'(we_n), 32'd2);
        check("swap_adr0", 32'(we_adr[0]), 32'd4);
        check("swap_dat0", 32'(we_dat[0]), 32'd2);
        check("swap_adr1", 32'(we_adr[1]), 32'd9);
        check("swap_dat1", 32'(we_dat[1]), 32'd1);
        check("swap_consec", 32'(we_cyc[1] - we_cyc[0]), 32'd1);
        do_cmd(C_READ, 4'd4, 4'd9, 16'h0, lat, ra, rb);
        check("rd49_a", 32'(ra), 32'd2);
        check("rd49_b", 32'(rb), 32'd1);

        // SWAP 4,4 leaves the register unchanged
        do_cmd(C_SWAP, 4'd4, 4'd4, 16'h0, lat, ra, rb);
        check("swap44_a", 32'(ra), 32'd2);
        check("swap44_b", 32'(rb), 32'd2);
        do_cmd(C_READ, 4'd4, 4'd4, 16'h0, lat, ra, rb);
        check("rd44_a", 32'(ra), 32'd2);

        // Backpressure: READ 7,1 held for 5 cycles while cmd_valid toggles
        cmd_op = C_READ; cmd_x = 4'd7; cmd_y = 4'd1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = ~cmd_valid; cmd_op = C_WRITE; cmd_x = 4'(i); cmd_wdata = 16'hF00D;
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_a",     32'(rsp_a),     32'hBEEF);
            check("bp_rsp_b",     32'(rsp_b),     32'd10);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_busy",      32'(busy),      32'd1);
            check("bp_rf_we",     32'(rf_we),     32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        check("bp_done_ready", 32'(cmd_ready), 32'd1);
        do_cmd(C_READ, 4'd0, 4'd1, 16'h0, lat, ra, rb);
        check("bp_no_write0", 32'(ra), 32'd10);
        check("bp_no_write1", 32'(rb), 32'd10);

        // Reset during WR1 of SWAP 4,9
        cmd_op = C_SWAP; cmd_x = 4'd4; cmd_y = 4'd9; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_wr1_we", 32'(rf_we), 32'd1);
        a_reset_l = 1'b0;
        #1;
        check("mid_rst_we",        32'(rf_we),     32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy",      32'(busy),      32'd0);
        @(posedge clk); #1;
        a_reset_l = 1'b1;
        @(posedge clk); #1;
        do_cmd(C_READ, 4'd4, 4'd9, 16'h0, lat, ra, rb);
        check("post_rst_a", 32'(ra), 32'd10);
        check("post_rst_b", 32'(rb), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
